// File: rtl/pipe_ctrl_decoder.sv
// Main control unit at the ID/EX boundary. It decodes the instruction in ID
// into the control bundle and registers it, which makes these flops the
// control half of the ID/EX pipeline register. It also inserts bubbles on
// load-use hazards and flushes, and holds IF/ID while a multiply runs.
module pipe_ctrl_decoder #(
  parameter int                 OP_W      = 6,
  parameter int                 FUNCT_W   = 6,
  parameter int                 RA_W      = 5,
  parameter int                 ALUOP_W   = 3,
  parameter int                 MUL_LAT   = 4,
  parameter logic [FUNCT_W-1:0] MUL_FUNCT = 6'b011000
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               id_valid_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic [FUNCT_W-1:0] instr_funct_i,
  input  logic [RA_W-1:0]    rs_i,
  input  logic [RA_W-1:0]    rt_i,
  input  logic               ex_memread_i,
  input  logic [RA_W-1:0]    ex_rt_i,
  input  logic               flush_i,
  output logic               id_ready_o,
  output logic               ctrl_valid_o,
  output logic               RegWrite_o,
  output logic [ALUOP_W-1:0] ALU_op_o,
  output logic               ALUSrc_o,
  output logic [1:0]         RegDst_o,
  output logic               Branch_o,
  output logic               sign_o,
  output logic [1:0]         BranchType_o,
  output logic               Jump_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic [1:0]         MemtoReg_o,
  output logic               mul_start_o,
  output logic               illegal_o
);

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BGTZ  = 6'b000111;
  localparam logic [OP_W-1:0] OP_BLTZ  = 6'b000001;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;

  // Cycles still to wait after the mult issues; the issuing cycle is one of them.
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

  typedef enum logic {RUN, MUL} state_t;

  typedef struct packed {
    logic               valid;
    logic               regWrite;
    logic [ALUOP_W-1:0] aluOp;
    logic               aluSrc;
    logic [1:0]         regDst;
    logic               branch;
    logic               sign;
    logic [1:0]         branchType;
    logic               jump;
    logic               memRead;
    logic               memWrite;
    logic [1:0]         memtoReg;
    logic               mulStart;
    logic               illegal;
  } ctrl_t;

  state_t     stateReg, stateNext;
  logic [3:0] cntReg, cntNext;
  ctrl_t      ctrlReg, ctrlNext, decoded;
  logic       legal, usesRt, isMult, hazard;

  // Opcode decode into the control bundle; unknown opcodes clear 'legal'.
  always_comb begin
    decoded = '0;
    legal   = 1'b1;
    usesRt  = 1'b0;
    case (instr_op_i)
      OP_RTYPE: begin decoded.regWrite = 1'b1; decoded.regDst = 2'b01; decoded.sign = 1'b1; usesRt = 1'b1; end
      OP_JAL:   begin decoded.regWrite = 1'b1; decoded.aluOp = ALUOP_W'(3'b011); decoded.regDst = 2'b10;
                      decoded.sign = 1'b1; decoded.jump = 1'b1; decoded.memtoReg = 2'b11; end
      OP_LW:    begin decoded.regWrite = 1'b1; decoded.aluOp = ALUOP_W'(3'b110); decoded.sign = 1'b1;
                      decoded.memRead = 1'b1; decoded.memtoReg = 2'b01; end
      OP_SW:    begin decoded.aluOp = ALUOP_W'(3'b110); decoded.sign = 1'b1; decoded.memWrite = 1'b1; usesRt = 1'b1; end
      OP_J:     begin decoded.aluOp = ALUOP_W'(3'b011); decoded.regDst = 2'b01; decoded.sign = 1'b1; decoded.jump = 1'b1; end
      OP_BEQ:   begin decoded.aluOp = ALUOP_W'(3'b011); decoded.regDst = 2'b01; decoded.branch = 1'b1;
                      decoded.sign = 1'b1; usesRt = 1'b1; end
      OP_BGTZ:  begin decoded.aluOp = ALUOP_W'(3'b011); decoded.regDst = 2'b01; decoded.branch = 1'b1;
                      decoded.sign = 1'b1; decoded.branchType = 2'b01; end
      OP_BLTZ:  begin decoded.aluOp = ALUOP_W'(3'b011); decoded.regDst = 2'b01; decoded.branch = 1'b1;
                      decoded.sign = 1'b1; decoded.branchType = 2'b10; end
      OP_BNE:   begin decoded.aluOp = ALUOP_W'(3'b011); decoded.regDst = 2'b01; decoded.branch = 1'b1;
                      decoded.sign = 1'b1; decoded.branchType = 2'b11; usesRt = 1'b1; end
      OP_ADDI, OP_LUI: begin decoded.regWrite = 1'b1; decoded.aluOp = ALUOP_W'(3'b110); decoded.sign = 1'b1; end
      OP_ORI:   begin decoded.regWrite = 1'b1; decoded.aluOp = ALUOP_W'(3'b101); end
      default:  legal = 1'b0;
    endcase
    if (legal) begin
      decoded.valid  = 1'b1;
      decoded.aluSrc = instr_op_i[3] | instr_op_i[5];
    end
  end

  assign isMult = (instr_op_i == OP_RTYPE) && (instr_funct_i == MUL_FUNCT);
  assign hazard = id_valid_i & ex_memread_i & (ex_rt_i != '0) &
                  ((ex_rt_i == rs_i) | (usesRt & (ex_rt_i == rt_i)));

  // Next state, next bundle and the combinational IF/ID ready.
  always_comb begin
    stateNext  = stateReg;
    cntNext    = cntReg;
    ctrlNext   = '0;
    id_ready_o = 1'b0;
    case (stateReg)
      RUN: begin
        id_ready_o = flush_i | ~hazard;
        if (!flush_i && !hazard && id_valid_i) begin
          if (!legal) begin
            ctrlNext.illegal = 1'b1;
          end else begin
            ctrlNext = decoded;
            if (isMult) begin
              ctrlNext.mulStart = 1'b1;
              if (MUL_LAT > 1) begin
                stateNext = MUL;
                cntNext   = MUL_CNT_INIT;
              end
            end
          end
        end
      end
      MUL: begin
        // A flush kills the wait early; otherwise count down to the last cycle.
        if (flush_i || cntReg == 4'd1) begin
          stateNext = RUN;
          cntNext   = '0;
        end else begin
          cntNext = cntReg - 4'd1;
        end
      end
    endcase
  end

  // State, counter and the registered control bundle.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= RUN;
      cntReg   <= '0;
      ctrlReg  <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      ctrlReg  <= ctrlNext;
    end
  end

  assign ctrl_valid_o = ctrlReg.valid;
  assign RegWrite_o   = ctrlReg.regWrite;
  assign ALU_op_o     = ctrlReg.aluOp;
  assign ALUSrc_o     = ctrlReg.aluSrc;
  assign RegDst_o     = ctrlReg.regDst;
  assign Branch_o     = ctrlReg.branch;
  assign sign_o       = ctrlReg.sign;
  assign BranchType_o = ctrlReg.branchType;
  assign Jump_o       = ctrlReg.jump;
  assign MemRead_o    = ctrlReg.memRead;
  assign MemWrite_o   = ctrlReg.memWrite;
  assign MemtoReg_o   = ctrlReg.memtoReg;
  assign mul_start_o  = ctrlReg.mulStart;
  assign illegal_o    = ctrlReg.illegal;

endmodule
